fetch_stage: RTL and testbench

- Instruction-fetch stage of the pipelined MIPS datapath.
- Owns the program counter, drives the instruction-memory address and computes PC+4.
- Captures the fetched word into the IF/ID boundary consumed by decode.
- Handles load-use stalls, taken-branch redirect/flush, and a halt instruction that freezes fetch.

---
 rtl/fetch_stage_pkg.sv | 17 +
 rtl/fetch_next_pc.sv | 30 +++
 rtl/fetch_stage.sv | 109 ++++++++++
 tb/tb_fetch_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
// State encoding, NOP word and opcode field bounds.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD        = 32'h0000_0000;
    localparam logic [5:0]  HALT_OPCODE_DEF = 6'h3F;
    localparam int unsigned OPC_HI          = 31;
    localparam int unsigned OPC_LO          = 26;
    localparam logic [31:0] PC_STEP         = 32'd4;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC select for the fetch stage.
// Chooses redirect target, PC+4 or hold.
module fetch_next_pc
    import fetch_stage_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        advance_i,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] pc_next_o
);

    // Low target bits are forced to word alignment.
    logic unused_tgt_lsb;
    assign unused_tgt_lsb = ^redirect_pc_i[1:0];

    assign pc_plus4_o = pc_i + PC_STEP;

    // Redirect beats advance, otherwise hold the current PC.
    always_comb begin
        pc_next_o = pc_i;
        if (redirect_i) begin
            pc_next_o = {redirect_pc_i[31:2], 2'b00};
        end else if (advance_i) begin
            pc_next_o = pc_plus4_o;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, IF/ID register, stall/redirect/halt.
// Priority per cycle: reset, redirect, stall, normal fetch.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = HALT_OPCODE_DEF,
    parameter int unsigned COUNT_W     = 16
) (
    input  logic               CLK,
    input  logic               RST,
    output logic [31:0]        imem_addr,
    input  logic [31:0]        imem_data,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_pc_i,
    output logic [31:0]        id_ins,
    output logic [31:0]        id_pc4,
    output logic               id_valid,
    output logic               halted,
    output logic [COUNT_W-1:0] fetch_count,
    output logic [COUNT_W-1:0] stall_count
);

    fetch_state_e        state_q;
    logic [31:0]         pc_q;
    logic [31:0]         pc_d;
    logic [31:0]         pc_plus4;
    logic [31:0]         ins_q;
    logic [31:0]         pc4_q;
    logic                valid_q;
    logic [COUNT_W-1:0]  fcnt_q;
    logic [COUNT_W-1:0]  scnt_q;

    logic                is_halt_word;
    logic                fetch_en;
    logic                advance;

    assign is_halt_word = (imem_data[OPC_HI:OPC_LO] == HALT_OPCODE);

    // A word is latched only outside HALT, with no stall and no redirect.
    assign fetch_en = !redirect_i && !stall_i && (state_q != ST_HALT);
    assign advance  = fetch_en && !is_halt_word;

    fetch_next_pc u_next_pc (
        .pc_i          (pc_q),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .advance_i     (advance),
        .pc_plus4_o    (pc_plus4),
        .pc_next_o     (pc_d)
    );

    // FSM, IF/ID register and saturating counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            ins_q   <= NOP_WORD;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
            fcnt_q  <= '0;
            scnt_q  <= '0;
        end else begin
            pc_q <= pc_d;
            if (redirect_i) begin
                state_q <= ST_RUN;
                ins_q   <= NOP_WORD;
                pc4_q   <= 32'h0;
                valid_q <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_RUN, ST_STALL: begin
                        if (stall_i) begin
                            state_q <= ST_STALL;
                            if (scnt_q != '1) begin
                                scnt_q <= scnt_q + 1'b1;
                            end
                        end else begin
                            ins_q   <= imem_data;
                            pc4_q   <= pc_plus4;
                            valid_q <= 1'b1;
                            if (fcnt_q != '1) begin
                                fcnt_q <= fcnt_q + 1'b1;
                            end
                            state_q <= is_halt_word ? ST_HALT : ST_RUN;
                        end
                    end
                    ST_HALT: begin
                        ins_q   <= NOP_WORD;
                        valid_q <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_RUN;
                    end
                endcase
            end
        end
    end

    assign imem_addr   = pc_q;
    assign id_ins      = ins_q;
    assign id_pc4      = pc4_q;
    assign id_valid    = valid_q;
    assign halted      = (state_q == ST_HALT);
    assign fetch_count = fcnt_q;
    assign stall_count = scnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed plan then random traffic.
// Expected outputs come from a per-cycle behavioural model.
module tb_fetch_stage;

    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic          CLK;
    logic          RST;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_data;
    logic          stall_i;
    logic          redirect_i;
    logic [31:0]   redirect_pc_i;
    logic [31:0]   id_ins;
    logic [31:0]   id_pc4;
    logic          id_valid;
    logic          halted;
    logic [CW-1:0] fetch_count;
    logic [CW-1:0] stall_count;

    fetch_stage #(
        .RESET_PC    (32'h0000_0000),
        .HALT_OPCODE (6'h3F),
        .COUNT_W     (CW)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .id_ins        (id_ins),
        .id_pc4        (id_pc4),
        .id_valid      (id_valid),
        .halted        (halted),
        .fetch_count   (fetch_count),
        .stall_count   (stall_count)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] pc4;
        logic        val;
        logic        hlt;
        int          fc;
        int          sc;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Program image: directed words, otherwise a hashed pattern with halts.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        case (a)
            32'h0000_0000: return 32'h2008_0001;
            32'h0000_0004: return 32'h2009_0002;
            32'h0000_0008: return 32'h0109_5020;
            32'h0000_0010: return 32'hFC00_0000;
            32'hFFFF_FFFC: return 32'h2010_0007;
            default: begin
                h = a * 32'h9E37_79B1;
                h = h ^ (h >> 15);
                if (h[3:0] == 4'h0) h[31:26] = 6'h3F;
                return h;
            end
        endcase
    endfunction

    always_comb imem_data = mem_word(imem_addr);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // One clock of the architectural behaviour of the fetch stage.
    task automatic model_step(input bit rst, input bit stl,
                              input bit rdr, input logic [31:0] tgt);
        logic [31:0] w;
        w = mem_word(m.pc);
        if (rst) begin
            m.pc = 32'h0; m.ins = 32'h0; m.pc4 = 32'h0;
            m.val = 1'b0; m.hlt = 1'b0; m.fc = 0; m.sc = 0;
        end else if (rdr) begin
            m.pc = tgt & 32'hFFFF_FFFC;
            m.ins = 32'h0; m.pc4 = 32'h0; m.val = 1'b0; m.hlt = 1'b0;
        end else if (m.hlt) begin
            m.ins = 32'h0; m.val = 1'b0;
        end else if (stl) begin
            m.sc = sat(m.sc);
        end else begin
            m.ins = w;
            m.pc4 = m.pc + 32'd4;
            m.val = 1'b1;
            m.fc  = sat(m.fc);
            if (w[31:26] == 6'h3F) m.hlt = 1'b1;
            else m.pc = m.pc + 32'd4;
        end
    endtask

    task automatic step(input bit rst, input bit stl,
                        input bit rdr, input logic [31:0] tgt);
        @(negedge CLK);
        RST = rst;
        stall_i = stl;
        redirect_i = rdr;
        redirect_pc_i = tgt;
        model_step(rst, stl, rdr, tgt);
        exp_q.push_back(m);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @%0t: got %08h expected %08h",
                     nm, $time, act, req);
        end
    endtask

    // Monitor: every output cycle is checked against the queued model state.
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("imem_addr", imem_addr, e.pc);
            chk("id_ins", id_ins, e.ins);
            chk("id_pc4", id_pc4, e.pc4);
            chk("id_valid", {31'b0, id_valid}, {31'b0, e.val});
            chk("halted", {31'b0, halted}, {31'b0, e.hlt});
            chk("fetch_count", 32'(fetch_count), 32'(e.fc));
            chk("stall_count", 32'(stall_count), 32'(e.sc));
        end
    end

    initial begin
        RST = 1'b1;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = 32'h0;
        m = '{pc: 32'h0, ins: 32'h0, pc4: 32'h0, val: 1'b0,
              hlt: 1'b0, fc: 0, sc: 0};

        step(1, 0, 0, 0);
        step(1, 1, 1, 32'h100);
        repeat (3) step(0, 0, 0, 0);
        repeat (2) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 1, 32'h0000_0043);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h0000_0010);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h0000_0020);
        repeat (2) step(0, 0, 0, 0);
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h0000_0024);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h0000_0010);
        step(0, 0, 0, 0);
        step(0, 1, 1, 32'h0000_0044);
        repeat (40) step(0, 1, 0, 0);
        repeat (40) step(0, 0, 0, 0);

        for (int i = 0; i < 2000; i++) begin
            step(($urandom % 64) == 0, ($urandom % 3) == 0,
                 ($urandom % 8) == 0, $urandom);
        end
        step(0, 0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
        #3;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
